// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between the I-cache and D-cache fill/store paths.
// Grants one client per transaction and routes read data/valid only to the owner.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_MemRead,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic                  d_MemRead,
  input  logic [ADDR_WIDTH-1:0] d_mem_addr,
  input  logic                  d_MemWrite,
  input  logic [ADDR_WIDTH-1:0] d_wr_addr,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_valid,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  i_grant,
  output logic                  d_grant,
  output logic                  i_MemDataValid,
  output logic                  d_MemDataValid,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_wr_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(WORDS_PER_BLOCK - 1);

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last_d;
  logic                 filling;
  logic                 fill_done;

  assign filling   = (state == I_FILL) || (state == D_FILL);
  // The fill ends on the edge that captures the final beat, so compare against N-1.
  assign fill_done = filling && mem_data_valid && (cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (filling && mem_data_valid) begin
        if (fill_done) cnt <= '0;
        else           cnt <= cnt + CNT_WIDTH'(1);
      end
      if (fill_done)
        last_d <= (state == D_FILL);
      else if (state == D_WRITE)
        last_d <= 1'b1;
    end
  end

  always_comb begin
    next_state     = state;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;
    i_grant        = 1'b0;
    d_grant        = 1'b0;
    i_MemDataValid = 1'b0;
    d_MemDataValid = 1'b0;
    i_data         = '0;
    d_data         = '0;
    d_wr_ack       = 1'b0;

    case (state)
      IDLE: begin
        // A pending I fill jumps ahead of D traffic once D has had the last turn.
        if (last_d && i_MemRead) next_state = I_FILL;
        else if (d_MemWrite)     next_state = D_WRITE;
        else if (d_MemRead)      next_state = D_FILL;
        else if (i_MemRead)      next_state = I_FILL;
      end
      I_FILL: begin
        i_grant        = 1'b1;
        mem_enable     = i_MemRead;
        mem_addr       = i_mem_addr;
        i_MemDataValid = mem_data_valid;
        i_data         = mem_data_out;
        if (fill_done) next_state = IDLE;
      end
      D_FILL: begin
        d_grant        = 1'b1;
        mem_enable     = d_MemRead;
        mem_addr       = d_mem_addr;
        d_MemDataValid = mem_data_valid;
        d_data         = mem_data_out;
        if (fill_done) next_state = IDLE;
      end
      D_WRITE: begin
        d_grant     = 1'b1;
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
